// File: rtl/ps2_rx_fifo_if.sv
// Read-side bus of ps2_rx_fifo: FWFT FIFO head, occupancy and status flags.
// The master modport is the receiver; the slave modport is the consumer.
interface ps2_rx_fifo_if #(
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          rd_en;
  logic [9:0]    data;
  logic          valid;
  logic [CW-1:0] count;
  logic          overflow;
  logic          parity_err;
  logic          frame_err;

  modport master (
    input  rd_en,
    output data, valid, count, overflow, parity_err, frame_err
  );

  modport slave (
    output rd_en,
    input  data, valid, count, overflow, parity_err, frame_err
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver (sync, glitch filter, framing, parity, timeout) feeding an FWFT FIFO.
// Define PS2_PREFIX_DECODE_EN to fold 0xE0/0xF0 prefixes into ext/brk bits of the next code.
module ps2_rx_fifo #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned TIMEOUT_CYC = 10000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps2c,
  input  logic          ps2d,
  ps2_rx_fifo_if.master bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic                  c_s1_q, c_s2_q, d_s1_q, d_s2_q;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  filt_q, filt_d;
  logic                  strobe_q, strobe_d;

  state_t        state_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] to_cnt_q;
  logic          push_q;
  logic [9:0]    push_data_q;
  logic          perr_q, ferr_q;
`ifdef PS2_PREFIX_DECODE_EN
  logic          ext_q, brk_q;
`endif

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;
  logic          full, do_pop, do_push;

  always_ff @(posedge clk) begin
    if (rst) begin
      {c_s1_q, c_s2_q, d_s1_q, d_s2_q} <= '1;
    end else begin
      c_s1_q <= ps2c;
      c_s2_q <= c_s1_q;
      d_s1_q <= ps2d;
      d_s2_q <= d_s1_q;
    end
  end

  // The filter decides on the history including the sample being shifted in,
  // so the bit strobe is registered in the same cycle filt_q falls.
  always_comb begin
    hist_d = {hist_q[FILTER_LEN-2:0], c_s2_q};
    filt_d = filt_q;
    if (hist_d == '0)      filt_d = 1'b0;
    else if (hist_d == '1) filt_d = 1'b1;
    strobe_d = filt_q & ~filt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q   <= '1;
      filt_q   <= 1'b1;
      strobe_q <= 1'b0;
    end else begin
      hist_q   <= hist_d;
      filt_q   <= filt_d;
      strobe_q <= strobe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
`ifdef PS2_PREFIX_DECODE_EN
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
`endif
    end else begin
      push_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      if (strobe_q) to_cnt_q <= '0;
      unique case (state_q)
        IDLE: begin
          to_cnt_q <= '0;
          if (strobe_q) begin
            if (!d_s2_q) begin
              state_q  <= DATA;
              bitcnt_q <= '0;
            end else begin
              ferr_q <= 1'b1;
`ifdef PS2_PREFIX_DECODE_EN
              ext_q  <= 1'b0;
              brk_q  <= 1'b0;
`endif
            end
          end
        end
        DATA: if (strobe_q) begin
          shift_q  <= {d_s2_q, shift_q[7:1]};
          bitcnt_q <= bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_q <= PARITY;
        end
        PARITY: if (strobe_q) begin
          par_q   <= d_s2_q;
          state_q <= STOP;
        end
        STOP: if (strobe_q) begin
          state_q <= IDLE;
          if (!d_s2_q || !(^{shift_q, par_q})) begin
            ferr_q <= ~d_s2_q;
            perr_q <= d_s2_q;
`ifdef PS2_PREFIX_DECODE_EN
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
`endif
          end else begin
`ifdef PS2_PREFIX_DECODE_EN
            if (shift_q == 8'hE0) ext_q <= 1'b1;
            else if (shift_q == 8'hF0) brk_q <= 1'b1;
            else begin
              push_q      <= 1'b1;
              push_data_q <= {ext_q, brk_q, shift_q};
              ext_q       <= 1'b0;
              brk_q       <= 1'b0;
            end
`else
            push_q      <= 1'b1;
            push_data_q <= {2'b00, shift_q};
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
      // Abort overrides the case above; it can only fire on cycles without a strobe.
      if (state_q != IDLE && !strobe_q) begin
        if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
          state_q  <= IDLE;
          ferr_q   <= 1'b1;
          to_cnt_q <= '0;
`ifdef PS2_PREFIX_DECODE_EN
          ext_q    <= 1'b0;
          brk_q    <= 1'b0;
`endif
        end else begin
          to_cnt_q <= to_cnt_q + TW'(1);
        end
      end
    end
  end

  always_comb begin
    full    = (cnt_q == CW'(FIFO_DEPTH));
    do_pop  = bus.rd_en && (cnt_q != '0);
    do_push = push_q && (!full || do_pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp_q] <= push_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
      if (push_q && !do_push) ovf_q <= 1'b1;
    end
  end

  assign bus.valid      = (cnt_q != '0);
  assign bus.data       = (cnt_q != '0) ? mem[rp_q] : '0;
  assign bus.count      = cnt_q;
  assign bus.overflow   = ovf_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo; PS/2 bit period and timeout are scaled down
// (80-cycle bit, 500-cycle timeout) to keep the run short.
module tb_ps2_rx_fifo;
  localparam int unsigned FL    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TO    = 500;
  localparam int unsigned H     = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2c = 1'b1;
  logic ps2d = 1'b1;

  ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  ps2_rx_fifo #(.FILTER_LEN(FL), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk  (clk),
    .rst  (rst),
    .ps2c (ps2c),
    .ps2d (ps2d),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int perr_n = 0;
  int ferr_n = 0;
  logic [9:0] exp_q[$];
  logic m_ext = 1'b0;
  logic m_brk = 1'b0;
  logic exp_ovf = 1'b0;

  always @(negedge clk) begin
    if (bus.parity_err === 1'b1) perr_n++;
    if (bus.frame_err === 1'b1)  ferr_n++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic v);
    ps2d = v;
    wait_cyc(H);
    ps2c = 1'b0;
    wait_cyc(H);
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ par_flip);
    ps2_bit(1'b1);
    ps2d = 1'b1;
    wait_cyc(H);
  endtask

  task automatic model_accept(input logic [7:0] b);
    logic [9:0] e;
`ifdef PS2_PREFIX_DECODE_EN
    if (b == 8'hE0) begin m_ext = 1'b1; return; end
    if (b == 8'hF0) begin m_brk = 1'b1; return; end
    e = {m_ext, m_brk, b};
    m_ext = 1'b0;
    m_brk = 1'b0;
`else
    e = {2'b00, b};
`endif
    if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
    else exp_q.push_back(e);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0);
    model_accept(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(1);
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    exp_ovf = 1'b0;
    perr_n = 0;
    ferr_n = 0;
  endtask

  task automatic drain(input string nm);
    logic [9:0] e;
    total++;
    if (bus.count !== exp_q.size()) begin
      bad++;
      $display("FAIL %s_count got=%0d exp=%0d", nm, bus.count, exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (bus.valid !== 1'b1 || bus.data !== e) begin
        bad++;
        $display("FAIL %s_data got=%h valid=%b exp=%h", nm, bus.data, bus.valid, e);
      end
      if (bus.valid !== 1'b1) exp_q.delete();
      bus.rd_en = 1'b1;
      wait_cyc(1);
      bus.rd_en = 1'b0;
    end
    total++;
    if (bus.valid !== 1'b0 || bus.count !== '0 || bus.data !== '0) begin
      bad++;
      $display("FAIL %s_empty got valid=%b count=%0d data=%h exp 0/0/000", nm, bus.valid, bus.count, bus.data);
    end
  endtask

  task automatic check_errs(input string nm, input int ep, input int ef);
    total++;
    if (perr_n !== ep || ferr_n !== ef) begin
      bad++;
      $display("FAIL %s_errs got perr=%0d ferr=%0d exp perr=%0d ferr=%0d", nm, perr_n, ferr_n, ep, ef);
    end
  endtask

  task automatic test_reset();
    bus.rd_en = 1'b0;
    do_reset();
    total++;
    if (bus.valid !== 1'b0 || bus.count !== '0 || bus.data !== '0 || bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got valid=%b count=%0d data=%h ovf=%b exp 0", bus.valid, bus.count, bus.data, bus.overflow);
    end
    total++;
    if (bus.parity_err !== 1'b0 || bus.frame_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_pulses got perr=%b ferr=%b exp 0", bus.parity_err, bus.frame_err);
    end
  endtask

  task automatic test_single();
    do_reset();
    send_good(8'h1C);
    total++;
    if (bus.valid !== 1'b1 || bus.count !== 1 || bus.data !== 10'h01C) begin
      bad++;
      $display("FAIL single got valid=%b count=%0d data=%h exp 1/1/01c", bus.valid, bus.count, bus.data);
    end
    drain("single");
    check_errs("single", 0, 0);
    // rd_en on an empty FIFO must be ignored
    bus.rd_en = 1'b1;
    wait_cyc(2);
    bus.rd_en = 1'b0;
    total++;
    if (bus.count !== '0 || bus.valid !== 1'b0) begin
      bad++;
      $display("FAIL empty_pop got count=%0d valid=%b exp 0/0", bus.count, bus.valid);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    ps2c = 1'b0;
    wait_cyc(FL - 3);
    ps2c = 1'b1;
    wait_cyc(2 * FL + 10);
    check_errs("glitch", 0, 0);
    total++;
    if (bus.count !== '0) begin
      bad++;
      $display("FAIL glitch_count got=%0d exp=0", bus.count);
    end
  endtask

  task automatic test_parity();
    do_reset();
    send_frame(8'h1C, 1'b1);
    check_errs("parity", 1, 0);
    total++;
    if (bus.count !== '0 || bus.valid !== 1'b0) begin
      bad++;
      $display("FAIL parity_count got=%0d valid=%b exp 0/0", bus.count, bus.valid);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i <= 16; i++) send_good(8'(i));
    total++;
    if (bus.count !== DEPTH || bus.overflow !== exp_ovf || exp_ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_full got count=%0d ovf=%b exp count=%0d ovf=1", bus.count, bus.overflow, DEPTH);
    end
    drain("ovf");
    wait_cyc(20);
    total++;
    if (bus.overflow !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky got=%b exp=1", bus.overflow);
    end
    do_reset();
    total++;
    if (bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear got=%b exp=0", bus.overflow);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2d = 1'b1;
    wait_cyc(TO + 10);
    wait_cyc(20);
    check_errs("timeout", 0, 1);
    total++;
    if (bus.count !== '0) begin
      bad++;
      $display("FAIL timeout_count got=%0d exp=0", bus.count);
    end
    send_good(8'h75);
    drain("after_timeout");
    check_errs("after_timeout", 0, 1);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] junk;
    junk = 8'hA5;
    do_reset();
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(junk[i]);
    ps2d = junk[5];
    wait_cyc(H / 2);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    exp_q.delete();
    m_ext = 1'b0;
    m_brk = 1'b0;
    wait_cyc(H);
    send_good(8'hF0);
    check_errs("rst_mid", 0, 0);
    drain("rst_mid");
  endtask

  task automatic test_prefix();
    do_reset();
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h75);
    drain("prefix");
    check_errs("prefix", 0, 0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    send_good(8'hFF);
    send_good(8'h00);
    send_good(8'h5A);
    send_good(8'h80);
    drain("b2b");
    check_errs("b2b", 0, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_parity();
    test_overflow();
    test_timeout();
    test_reset_midframe();
    test_prefix();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Synthesizable PS/2 keyboard receiver feeding a parametrised first-word-fall-through FIFO.
- Sits between the board PS2C/PS2D pins and the game logic in top; replaces direct pin sampling.
- Adds filtering, odd-parity check, frame timeout, buffering, overflow flag and optional scan-code prefix decoding.

Parameters:
- FILTER_LEN, 8, number of consecutive equal ps2c samples required to change the filtered clock level (>=2).
- FIFO_DEPTH, 16, FIFO entries; power of two, >=2.
- TIMEOUT_CYC, 10000, clk cycles without a filtered falling edge before an in-progress frame is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ps2c  in  1  raw PS/2 clock, asynchronous
- ps2d  in  1  raw PS/2 data, asynchronous
- rd_en  in  1  pop request; acted on only when valid=1
- data  out  10  FIFO head: {ext, brk, code[7:0]}
- valid  out  1  FIFO non-empty; data is meaningful
- count  out  $clog2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  sticky: a byte was dropped because FIFO was full
- parity_err  out  1  one-cycle pulse: frame discarded for bad parity
- frame_err  out  1  one-cycle pulse: bad start, bad stop, or timeout

Behaviour:
- Reset (synchronous, rst=1 at clk edge): FSM IDLE, FIFO empty, count=0, valid=0, data=0, overflow=0, both error pulses 0, filter history all ones, filtered clock=1, timeout counter 0, prefix flags cleared. Reset mid-frame discards the partial frame.
- Input path: ps2c and ps2d each pass through a 2-flop synchronizer. Filtered clock goes 0 when last FILTER_LEN synced samples are all 0, goes 1 when all 1, otherwise holds. Registered falling edge of filtered clock = bit strobe; synced ps2d sampled on the strobe.
- Frame: start(0), 8 data bits LSB first, odd parity, stop(1).
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: strobe with d=0 -> DATA, bit counter 0. Strobe with d=1 -> stay IDLE, frame_err pulse.
  - DATA: shift in bit; after 8th bit -> PARITY.
  - PARITY: capture bit -> STOP.
  - STOP: on strobe -> IDLE. d=0 -> frame_err, discard. Else parity mismatch (XOR of 8 data bits and parity bit != 1) -> parity_err, discard. Else the byte is accepted.
  - Timeout: counter cleared on every strobe and in IDLE; in any non-IDLE state reaching TIMEOUT_CYC -> IDLE, frame_err pulse, partial data discarded.
- Accepted byte is pushed in the clk cycle after the stop strobe. Data/valid is visible the cycle after the push. Total delay from raw stop-bit falling edge to valid <= FILTER_LEN+5 cycles.
- FIFO: first-word-fall-through; data shows the head whenever valid=1; rd_en&valid pops at clk edge; rd_en with valid=0 is ignored.
- Push while full and no pop: byte dropped, overflow set and held until rst. Push and pop in the same cycle, including when full: both take effect, count unchanged, no overflow. Pointers wrap modulo FIFO_DEPTH.
- Only one error pulse is asserted per frame. Error pulses never push.

Optional Feature:
- Macro PS2_PREFIX_DECODE_EN.
- Defined: byte 0xE0 sets ext flag, byte 0xF0 sets brk flag; neither is pushed. The next other byte is pushed as {ext,brk,code} and both flags are cleared. Flags are also cleared on rst, frame_err and parity_err.
- Undefined: every accepted byte is pushed as {2'b00,code}; no flags exist.

Test Plan:
- Send 0x1C (parity 0) with 30 us PS/2 bit period -> exactly one entry, data=0x01C, valid=1, count=1; rd_en pulse -> valid=0, count=0.
- Send 0x1C with parity bit 1 -> parity_err single pulse, count stays 0, no frame_err.
- Send 17 bytes 0x00..0x10 with no reads, FIFO_DEPTH=16 -> count=16, overflow=1, sequential reads return 0x000..0x00F and then valid=0. Overflow stays 1 until rst.
- Send start+3 data bits, then hold ps2c high for TIMEOUT_CYC+10 cycles -> frame_err pulse once. Then send 0x75 -> data=0x075.
- Assert rst for 1 cycle during bit 5 of a frame, then send 0xF0 -> no error, FIFO holds only the post-reset frame.
- Send 0xE0, 0xF0, 0x75. With PS2_PREFIX_DECODE_EN -> one entry 0x375. Without -> three entries 0x0E0, 0x0F0, 0x075.
